bus_arbiter_2to1: RTL and testbench

//  - Shares one DATA_W-bit bus between requesters A and B using round-robin arbitration.
//  - Registered grants, with a bounded hold time per owner.
//  - Drives the select of a 2:1 datapath mux; bus_data carries the owner's data.
//  - Sits between CPU bus masters (e.g. fetch and load/store) and the shared internal bus.

---
 rtl/bus_arbiter_2to1_pkg.sv | 15 +
 rtl/bus_arbiter_2to1_mux.sv | 11 +
 rtl/bus_arbiter_2to1.sv | 88 ++++++++
 tb/tb_bus_arbiter_2to1.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_2to1_pkg.sv
// bus_arbiter_2to1_pkg: state encodings and owner identifiers shared by the arbiter files.
package bus_arbiter_2to1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_e;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    localparam int HOLD_W = 4;

endpackage

// File: rtl/bus_arbiter_2to1_mux.sv
// bus_arbiter_2to1_mux: the team's 8-bit 2:1 mux cell; sel_i=0 picks a_i, sel_i=1 picks b_i.
module bus_arbiter_2to1_mux (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       sel_i,
    output logic [7:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/bus_arbiter_2to1.sv
// bus_arbiter_2to1: round-robin arbiter sharing one bus between requesters A and B,
// with registered grants and a bounded hold time while the other side waits.
module bus_arbiter_2to1
    import bus_arbiter_2to1_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              select,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_valid,
    output logic              last_owner
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            sel_q   <= OWNER_A;
            last_q  <= OWNER_B;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ST_OWN_A: state_d = !req_a ? (req_b ? ST_OWN_B : ST_IDLE) :
                                (hold_q == HOLD_MAX && req_b) ? ST_OWN_B : ST_OWN_A;
            ST_OWN_B: state_d = !req_b ? (req_a ? ST_OWN_A : ST_IDLE) :
                                (hold_q == HOLD_MAX && req_a) ? ST_OWN_A : ST_OWN_B;
            default:  state_d = (req_a && req_b) ? (last_q == OWNER_B ? ST_OWN_A : ST_OWN_B) :
                                req_a ? ST_OWN_A : req_b ? ST_OWN_B : ST_IDLE;
        endcase
        // Any change of owner is a fresh grant entry: restart the hold count and steer the mux.
        if (state_d == ST_IDLE) begin
            hold_d = '0;
        end else if (state_d != state_q) begin
            hold_d = HOLD_W'(1);
            sel_d  = (state_d == ST_OWN_B) ? OWNER_B : OWNER_A;
            last_d = sel_d;
        end else begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
        end
    end

    assign gnt_a      = (state_q == ST_OWN_A);
    assign gnt_b      = (state_q == ST_OWN_B);
    assign bus_valid  = gnt_a | gnt_b;
    assign select     = sel_q;
    assign last_owner = last_q;

    generate
        if (DATA_W == 8) begin : g_cell
            bus_arbiter_2to1_mux u_mux (
                .a_i  (data_a),
                .b_i  (data_b),
                .sel_i(sel_q),
                .y_o  (bus_data)
            );
        end else begin : g_wide
            assign bus_data = sel_q ? data_b : data_a;
        end
    endgenerate

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// tb_bus_arbiter_2to1: directed scenarios plus randomized traffic checked every cycle
// against an ownership model built from the arbitration rules.
module tb_bus_arbiter_2to1;

    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_a = 1'b0;
    logic              req_b = 1'b0;
    logic [DATA_W-1:0] data_a = '0;
    logic [DATA_W-1:0] data_b = '0;
    logic              gnt_a, gnt_b, select, bus_valid, last_owner;
    logic [DATA_W-1:0] bus_data;

    int n_pass  = 0;
    int n_total = 0;

    bus_arbiter_2to1 #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .select    (select),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .last_owner(last_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    endtask

    // Model: owner (-1 none, 0 A, 1 B), cycles owned so far, most recent owner, mux side.
    int m_own  = -1;
    int m_run  = 0;
    int m_last = 1;
    int m_sel  = 0;
    bit m_ok   = 1'b0;

    function automatic bit rq(input int side);
        return side == 0 ? req_a : req_b;
    endfunction

    always @(posedge clk) begin
        int nxt;
        if (rst) begin
            m_own = -1; m_run = 0; m_last = 1; m_sel = 0; m_ok = 1'b1;
        end else if (m_ok) begin
            if (m_own >= 0) begin
                if (rq(m_own) && !(m_run >= MAX_HOLD && rq(1 - m_own))) nxt = m_own;
                else if (rq(1 - m_own)) nxt = 1 - m_own;
                else nxt = -1;
            end else begin
                if (req_a && req_b) nxt = 1 - m_last;
                else if (req_a) nxt = 0;
                else if (req_b) nxt = 1;
                else nxt = -1;
            end
            if (nxt >= 0 && nxt != m_own) begin
                m_run = 1; m_sel = nxt; m_last = nxt;
            end else if (nxt >= 0) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            m_own = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("gnt_a", 32'(gnt_a), 32'(m_own == 0));
            chk("gnt_b", 32'(gnt_b), 32'(m_own == 1));
            chk("select", 32'(select), 32'(m_sel));
            chk("last_owner", 32'(last_owner), 32'(m_last));
            chk("bus_valid", 32'(bus_valid), 32'(m_own >= 0));
            chk("gnt_exclusive", 32'(gnt_a & gnt_b), 32'd0);
            if (m_own >= 0) chk("bus_data", 32'(bus_data), 32'(m_sel != 0 ? data_b : data_a));
        end
    end

    task automatic cyc(input logic ra, input logic rb, input logic r);
        req_a = ra; req_b = rb; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        chk("t1_gnt_a", 32'(gnt_a), 32'd0);
        chk("t1_gnt_b", 32'(gnt_b), 32'd0);
        chk("t1_select", 32'(select), 32'd0);
        chk("t1_last", 32'(last_owner), 32'd1);
        chk("t1_valid", 32'(bus_valid), 32'd0);
        // Lone requester keeps the bus
        data_a = 8'h3C;
        cyc(1'b1, 1'b0, 1'b0);
        chk("t2_gnt_a", 32'(gnt_a), 32'd1);
        chk("t2_bus_data", 32'(bus_data), 32'h3C);
        for (int i = 0; i < 20; i++) begin
            data_b = 8'($urandom);
            cyc(1'b1, 1'b0, 1'b0);
            chk("t2_hold", 32'({gnt_a, gnt_b}), 32'b10);
        end
        // Simultaneous requests alternate A4/B4 with no gap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk("t3_a_phase", 32'({gnt_a, gnt_b}), 32'b10);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk("t3_b_phase", 32'({gnt_a, gnt_b}), 32'b01);
        end
        cyc(1'b1, 1'b1, 1'b0);
        chk("t3_back_to_a", 32'({gnt_a, gnt_b}), 32'b10);
        // Owner drops with nobody waiting; select holds through IDLE
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        chk("t4_gnt_b", 32'(gnt_b), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t4_idle", 32'({gnt_a, gnt_b, bus_valid}), 32'b000);
        chk("t4_select_held", 32'(select), 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t4_regrant", 32'(gnt_b), 32'd1);
        // Owner drops mid-hold while other waits: direct handoff
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t5_handoff", 32'({gnt_a, gnt_b}), 32'b01);
        chk("t5_select", 32'(select), 32'd1);
        // Full hold still available after handoff (hold restarted at 1)
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        chk("t5_hold_restart", 32'(gnt_b), 32'd1);
        // Reset mid-ownership
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("t6_reset_gnts", 32'({gnt_a, gnt_b}), 32'b00);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t6_a_first", 32'({gnt_a, gnt_b}), 32'b10);
        // Randomized traffic with sticky requests and rare resets
        for (int i = 0; i < 3000; i++) begin
            logic ra, rb, r;
            ra = ($urandom_range(0, 9) < 2) ? ~req_a : req_a;
            rb = ($urandom_range(0, 9) < 2) ? ~req_b : req_b;
            r  = ($urandom_range(0, 199) == 0);
            data_a = 8'($urandom);
            data_b = 8'($urandom);
            cyc(ra, rb, r);
        end
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
